ecc_point_decoder: RTL
======================

// Module: ecc_point_decoder
// PURPOSE
//  Byte-serial SEC1 decoder for EC public points: the inverse of the core's point-to-octet encoder.
//  Consumes 0x04||X||Y (uncompressed) or 0x02/0x03||X (compressed) frames big-endian, MSB byte first.
//  Emits X, Y, the point format and an error code, so imported public keys enter the key store.
//  Sits between the host byte stream and the key register file.
// PARAMETERS
//  COORD_BYTES  32          bytes per coordinate (32 = P-256, 48 = P-384, 66 = P-521)
//  P_MODULUS    P-256 prime field prime, 8*COORD_BYTES bits; used only when range check compiled in
// PORTS
//  clk          in   1              single clock, rising edge
//  rst          in   1              synchronous, active-high reset
//  in_valid     in   1              input byte valid
//  in_ready     out  1              decoder accepts byte (transfer = in_valid & in_ready)
//  in_data      in   8              frame byte
//  in_last      in   1              final byte of frame
//  out_valid    out  1              result valid; held until out_ready
//  out_ready    in   1              downstream accepts result
//  out_x        out  8*COORD_BYTES  X coordinate, big-endian packed
//  out_y        out  8*COORD_BYTES  Y coordinate; zero for compressed frames
//  out_fmt      out  2              0 = uncompressed; 2/3 = compressed, Y parity = out_fmt[0]
//  out_err      out  3              0 = OK, 1 = PREFIX, 2 = SHORT, 3 = LONG, 4 = INFINITY, 5 = RANGE
// BEHAVIOUR
//  Reset: FSM = IDLE; in_ready = 1; out_valid = 0; out_x, out_y, out_fmt and out_err = 0.
//  FSM states: IDLE, XCRD, YCRD, DRAIN, DONE. in_ready = 1 in every state except DONE.
//  IDLE, first byte:
//    0x04 -> XCRD, fmt = 0.
//    0x02/0x03 -> XCRD, fmt = byte[1:0].
//    0x00 -> err = INFINITY.
//    Any other value -> err = PREFIX.
//    On error: with in_last -> DONE, else -> DRAIN.
//  byte_cnt counts 0..COORD_BYTES-1 and resets on each coordinate change.
//    Each byte shifts into the coordinate register LSB end: x <= {x[8*COORD_BYTES-9:0], in_data}.
//  XCRD last byte, uncompressed -> YCRD.
//  XCRD last byte, compressed -> DONE if in_last, else DRAIN with err = LONG.
//  YCRD last byte -> DONE if in_last, else DRAIN with err = LONG.
//  in_last on any earlier byte of XCRD or YCRD -> DONE with err = SHORT; x and y hold partial data.
//  DRAIN discards bytes until in_last, then goes to DONE. The first error latched is kept.
//  DONE: out_valid = 1, outputs stable. On out_valid & out_ready -> IDLE, and registers clear the next cycle.
//  Latency: out_valid rises the cycle after the final byte transfer.
//  Throughput: one byte per clock, plus one DONE cycle per frame minimum.
//  Reset mid-frame discards the partial frame. The next byte after reset is treated as a prefix.
//  out_x and out_y are driven to zero unless err is OK or RANGE.
// CONFIGURATION
//  ECC_RANGE_CHECK_EN defined:
//    Serial MSB-first compare of each coordinate against P_MODULUS, running in parallel with the shift.
//    Y is not compared for compressed frames.
//    Coordinate >= P_MODULUS sets err = RANGE at frame end, only if no other error occurred.
//    Adds no extra latency.
//  Not defined:
//    No comparator logic is built; RANGE is never reported.
// STRUCTURE
//  ecc_codec_pkg: err_e (6 codes above), fmt_e, state_e, SEC1 prefix constants 0x00/0x02/0x03/0x04.
//  Sub-module ecc_serial_cmp: byte-serial a-vs-b compare.
//    Ports: clk, rst, start, en, a_byte, b_byte; outputs lt, eq.
//    Instantiated only under ECC_RANGE_CHECK_EN; P_MODULUS byte selected by byte_cnt.
// TESTING (COORD_BYTES = 32)
//  1. 65-byte frame 0x04, X = 0x01..0x20, Y = 0x21..0x40, last on byte 65, out_ready = 1
//     -> out_valid one cycle later; fmt 0; err 0; X and Y match input; in_ready low for one cycle.
//  2. 33-byte frame 0x03 || X, last on byte 33 -> fmt 3, Y = 0, err 0.
//  3. 0x05 followed by 9 bytes, last on byte 10 -> all bytes consumed, err PREFIX, X = Y = 0.
//     Also single byte 0x00 with last -> err INFINITY.
//  4. Uncompressed frame with last on byte 40 -> err SHORT.
//     Uncompressed frame of 70 bytes -> err LONG, out_valid only after byte 70.
//  5. With ECC_RANGE_CHECK_EN: X = all 0xFF (>= P-256 prime) -> err RANGE.
//     X = prime minus 1 -> err 0. Without the macro, the same frames -> err 0.
//  6. out_ready held low for 5 cycles in DONE -> outputs stable, in_ready 0.
//     rst asserted mid-YCRD -> out_valid 0, next frame decodes correctly.

Source files
------------

// File: rtl/ecc_codec_pkg.sv
// ecc_codec_pkg: shared types and SEC1 constants for the EC point decoder
package ecc_codec_pkg;
  typedef enum logic [2:0] {
    ERR_OK     = 3'd0,
    ERR_PREFIX = 3'd1,
    ERR_SHORT  = 3'd2,
    ERR_LONG   = 3'd3,
    ERR_INF    = 3'd4,
    ERR_RANGE  = 3'd5
  } err_e;
  typedef enum logic [1:0] {
    FMT_UNC      = 2'd0,
    FMT_CMP_EVEN = 2'd2,
    FMT_CMP_ODD  = 2'd3
  } fmt_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XCRD,
    ST_YCRD,
    ST_DRAIN,
    ST_DONE
  } state_e;
  localparam logic [7:0] SEC1_INF      = 8'h00;
  localparam logic [7:0] SEC1_CMP_EVEN = 8'h02;
  localparam logic [7:0] SEC1_CMP_ODD  = 8'h03;
  localparam logic [7:0] SEC1_UNC      = 8'h04;
  localparam logic [255:0] P256_P =
    256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
endpackage

// File: rtl/ecc_point_decoder_if.sv
// ecc_point_decoder_if: byte-stream input and decoded-point output of the point decoder
// master = byte source / result sink, slave = decoder.
interface ecc_point_decoder_if #(
  parameter int COORD_BYTES = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [8*COORD_BYTES-1:0] out_x;
  logic [8*COORD_BYTES-1:0] out_y;
  logic [1:0]               out_fmt;
  logic [2:0]               out_err;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_fmt, out_err
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_x, out_y, out_fmt, out_err
  );
endinterface

// File: rtl/ecc_serial_cmp.sv
// ecc_serial_cmp: byte-serial MSB-first unsigned compare of a against b
// Ports: clk, rst; i_start marks the first (most significant) byte, i_en qualifies a byte;
// o_lt/o_eq already include the byte presented this cycle when i_en is high.
module ecc_serial_cmp (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_en,
  input  logic [7:0] i_a_byte,
  input  logic [7:0] i_b_byte,
  output logic       o_lt,
  output logic       o_eq
);
  logic r_lt, r_eq, w_blt, w_beq, w_lt, w_eq;
  always_comb begin
    w_blt = i_start ? 1'b0 : r_lt;
    w_beq = i_start ? 1'b1 : r_eq;
    w_lt  = w_blt | (w_beq & (i_a_byte < i_b_byte));
    w_eq  = w_beq & (i_a_byte == i_b_byte);
    o_lt  = i_en ? w_lt : r_lt;
    o_eq  = i_en ? w_eq : r_eq;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lt <= 1'b0;
      r_eq <= 1'b1;
    end else if (i_en) begin
      r_lt <= w_lt;
      r_eq <= w_eq;
    end
  end
endmodule

// File: rtl/ecc_point_decoder.sv
// ecc_point_decoder: byte-serial SEC1 EC public point decoder (0x04||X||Y, 0x02/0x03||X)
// Ports: clk, rst (sync, active-high); bus (ecc_point_decoder_if.slave) carries the
// in_valid/in_ready/in_data/in_last byte stream and the out_valid/out_ready/x/y/fmt/err result.
// Define ECC_RANGE_CHECK_EN to report coordinates >= P_MODULUS as ERR_RANGE.
module ecc_point_decoder
  import ecc_codec_pkg::*;
#(
  parameter int COORD_BYTES = 32,
  parameter logic [8*COORD_BYTES-1:0] P_MODULUS = P256_P
) (
  input logic clk,
  input logic rst,
  ecc_point_decoder_if.slave bus
);
  localparam int W  = 8*COORD_BYTES;
  localparam int CW = $clog2(COORD_BYTES);
  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_x, r_y;
  fmt_e          r_fmt;
  err_e          r_err;
  logic          r_rng;
  logic          w_xfer, w_cnt_end, w_ge, w_pass, w_pfx_ok;
  assign w_xfer    = bus.in_valid && bus.in_ready;
  assign w_cnt_end = r_cnt == CW'(COORD_BYTES-1);
  assign w_pfx_ok  = bus.in_data inside {SEC1_UNC, SEC1_CMP_EVEN, SEC1_CMP_ODD};
`ifdef ECC_RANGE_CHECK_EN
  logic [W-1:0] w_psh;
  logic         w_lt, w_eq_unused;
  // Modulus byte for the current position: shift it up to the MSB lane.
  assign w_psh = P_MODULUS << {r_cnt, 3'b000};
  ecc_serial_cmp u_cmp (
    .clk,
    .rst,
    .i_start (r_cnt == '0),
    .i_en    (w_xfer && (r_state == ST_XCRD || r_state == ST_YCRD)),
    .i_a_byte(bus.in_data),
    .i_b_byte(w_psh[W-1 -: 8]),
    .o_lt    (w_lt),
    .o_eq    (w_eq_unused)
  );
  assign w_ge = !w_lt;
`else
  logic w_unused;
  assign w_unused = ^P_MODULUS;
  assign w_ge     = 1'b0;
`endif
  assign w_pass        = r_err == ERR_OK || r_err == ERR_RANGE;
  assign bus.in_ready  = r_state != ST_DONE;
  assign bus.out_valid = r_state == ST_DONE;
  assign bus.out_x     = w_pass ? r_x : '0;
  assign bus.out_y     = w_pass ? r_y : '0;
  assign bus.out_fmt   = r_fmt;
  assign bus.out_err   = r_err;
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_DONE && bus.out_ready)) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_fmt   <= FMT_UNC;
      r_err   <= ERR_OK;
      r_rng   <= 1'b0;
    end else if (w_xfer) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pfx_ok) begin
            r_fmt   <= bus.in_data == SEC1_UNC ? FMT_UNC : fmt_e'(bus.in_data[1:0]);
            r_state <= bus.in_last ? ST_DONE : ST_XCRD;
            if (bus.in_last) r_err <= ERR_SHORT;
          end else begin
            r_err   <= bus.in_data == SEC1_INF ? ERR_INF : ERR_PREFIX;
            r_state <= bus.in_last ? ST_DONE : ST_DRAIN;
          end
        end
        ST_XCRD: begin
          r_x   <= {r_x[W-9:0], bus.in_data};
          r_cnt <= w_cnt_end ? '0 : r_cnt + CW'(1);
          if (w_cnt_end && r_fmt == FMT_UNC) begin
            // X range verdict is parked until Y completes.
            r_rng   <= w_ge;
            r_state <= bus.in_last ? ST_DONE : ST_YCRD;
            if (bus.in_last) r_err <= ERR_SHORT;
          end else if (w_cnt_end) begin
            r_state <= bus.in_last ? ST_DONE : ST_DRAIN;
            r_err   <= bus.in_last ? (w_ge ? ERR_RANGE : ERR_OK) : ERR_LONG;
          end else if (bus.in_last) begin
            r_state <= ST_DONE;
            r_err   <= ERR_SHORT;
          end
        end
        ST_YCRD: begin
          r_y   <= {r_y[W-9:0], bus.in_data};
          r_cnt <= w_cnt_end ? '0 : r_cnt + CW'(1);
          if (w_cnt_end) begin
            r_state <= bus.in_last ? ST_DONE : ST_DRAIN;
            r_err   <= bus.in_last ? ((r_rng || w_ge) ? ERR_RANGE : ERR_OK) : ERR_LONG;
          end else if (bus.in_last) begin
            r_state <= ST_DONE;
            r_err   <= ERR_SHORT;
          end
        end
        ST_DRAIN: r_state <= bus.in_last ? ST_DONE : ST_DRAIN;
        default: r_state <= r_state;
      endcase
    end
  end
endmodule
